// File: rtl/hash_pkg.sv
// Shared types for the hash round controller and its datapath.
package hash_pkg;

    localparam int BLK_BYTES = 4;

    typedef enum logic [2:0] {
        RND_IDLE       = 3'b000,
        RND_CALC_SA    = 3'b001,
        RND_CALC_ROUND = 3'b010,
        RND_CALC_FINAL = 3'b011,
        RND_DONE       = 3'b100
    } rnd_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SA,
        S_ROUND,
        S_FINAL,
        S_DONE
    } ctrl_state_t;

    typedef logic [0:BLK_BYTES-1][7:0] word_t;

    function automatic rnd_state_t rnd_code(ctrl_state_t s);
        case (s)
            S_SA:    return RND_CALC_SA;
            S_ROUND: return RND_CALC_ROUND;
            S_FINAL: return RND_CALC_FINAL;
            S_DONE:  return RND_DONE;
            default: return RND_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/hash_ctrl_packer.sv
// Gathers message bytes into a zero-padded 4-byte block and tracks the last flag.
module msg_packer
    import hash_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    input  logic       byte_last,
    output word_t      block,
    output logic       block_done,
    output logic       last
);

    word_t      block_q, block_d;
    logic [1:0] cnt_q, cnt_d;
    logic       last_q, last_d;

    always_comb begin
        block_d    = block_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        block_done = byte_valid && ((cnt_q == 2'(BLK_BYTES - 1)) || byte_last);
        if (clear) begin
            block_d = '0;
            cnt_d   = '0;
        end else if (byte_valid) begin
            block_d[cnt_q] = byte_in;
            cnt_d          = cnt_q + 2'd1;
            if (block_done) begin
                last_d = byte_last;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            block_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            block_q <= block_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign block = block_q;
    assign last  = last_q;

endmodule

// File: rtl/hash_ctrl.sv
// Sequencer for the 4-byte hash round datapath: packs bytes, runs rounds, chains blocks.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_LOAD  | accepting message bytes into the block buffer
//   S_SA    | first datapath cycle, block and chain presented
//   S_ROUND | datapath output fed back as H_in
//   S_FINAL | chain captures datapath output
//   S_DONE  | digest presented until consumed
module hash_ctrl
    import hash_pkg::*;
#(
    parameter int NUM_ROUNDS = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  word_t       iv_in,
    input  logic [7:0]  msg_byte,
    input  logic        msg_valid,
    input  logic        msg_last,
    output logic        msg_ready,
    output logic [2:0]  rnd_state,
    output word_t       rnd_h_in,
    output word_t       rnd_iv,
    input  word_t       rnd_h_out,
    output word_t       digest,
    output logic        digest_valid,
    input  logic        digest_ready,
    output logic        busy
);

    ctrl_state_t      state_q, state_d;
    word_t            chain_q, chain_d;
    logic [CNT_W-1:0] rnd_cnt_q, rnd_cnt_d;
    rnd_state_t       rnd_state_q, rnd_state_d;
    logic             msg_ready_q, msg_ready_d;
    logic             busy_q, busy_d;
    logic             digest_valid_q, digest_valid_d;
    word_t            digest_q, digest_d;

    word_t            pk_block;
    logic             pk_done;
    logic             pk_last;
    logic             pk_clear;
    logic             accept;

    assign accept   = msg_valid && msg_ready_q;
    assign pk_clear = (state_q == S_FINAL) || ((state_q == S_IDLE) && start);

    msg_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .byte_valid (accept),
        .byte_in    (msg_byte),
        .byte_last  (msg_last),
        .block      (pk_block),
        .block_done (pk_done),
        .last       (pk_last)
    );

    always_comb begin
        state_d   = state_q;
        chain_d   = chain_q;
        rnd_cnt_d = rnd_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    chain_d = iv_in;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (pk_done) begin
                    state_d = S_SA;
                end
            end
            S_SA: begin
                rnd_cnt_d = CNT_W'(1);
                state_d   = (NUM_ROUNDS > 1) ? S_ROUND : S_FINAL;
            end
            S_ROUND: begin
                rnd_cnt_d = rnd_cnt_q + CNT_W'(1);
                if (rnd_cnt_q == CNT_W'(NUM_ROUNDS - 1)) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                // Datapath register clears on this same edge, so H_out is still valid here.
                chain_d = rnd_h_out;
                state_d = pk_last ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                if (digest_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rnd_state_d    = rnd_code(state_d);
        msg_ready_d    = (state_d == S_LOAD);
        busy_d         = (state_d != S_IDLE);
        digest_valid_d = (state_d == S_DONE);
        digest_d       = (state_d == S_DONE) ? chain_d : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            chain_q        <= '0;
            rnd_cnt_q      <= '0;
            rnd_state_q    <= RND_IDLE;
            msg_ready_q    <= 1'b0;
            busy_q         <= 1'b0;
            digest_valid_q <= 1'b0;
            digest_q       <= '0;
        end else begin
            state_q        <= state_d;
            chain_q        <= chain_d;
            rnd_cnt_q      <= rnd_cnt_d;
            rnd_state_q    <= rnd_state_d;
            msg_ready_q    <= msg_ready_d;
            busy_q         <= busy_d;
            digest_valid_q <= digest_valid_d;
            digest_q       <= digest_d;
        end
    end

    // H_in in ROUND is a straight wire from H_out; the datapath register breaks the loop.
    always_comb begin
        rnd_h_in = '0;
        rnd_iv   = '0;
        case (state_q)
            S_SA: begin
                rnd_h_in = pk_block;
                rnd_iv   = chain_q;
            end
            S_ROUND, S_FINAL: begin
                rnd_h_in = rnd_h_out;
                rnd_iv   = chain_q;
            end
            default: ;
        endcase
    end

    assign rnd_state    = rnd_state_q;
    assign msg_ready    = msg_ready_q;
    assign busy         = busy_q;
    assign digest_valid = digest_valid_q;
    assign digest       = digest_q;

endmodule

// File: tb/tb_hash_ctrl.sv
// Bench for hash_ctrl: two builds (4 rounds and 1 round) beside a toy round datapath.
module tb_hash_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1, sel;
    logic        start, msg_valid, msg_last, digest_ready;
    logic [31:0] iv_in;
    logic [7:0]  msg_byte;

    logic        msg_ready0, digest_valid0, busy0;
    logic        msg_ready1, digest_valid1, busy1;
    logic [2:0]  rnd_state0, rnd_state1;
    logic [31:0] rnd_h_in0, rnd_iv0, rnd_h_out0, digest0, h_dp0;
    logic [31:0] rnd_h_in1, rnd_iv1, rnd_h_out1, digest1, h_dp1;

    logic        msg_ready_m, digest_valid_m, busy_m;
    logic [2:0]  rnd_state_m;
    logic [31:0] rnd_h_in_m, rnd_iv_m, digest_m;

    int          n_chk = 0, n_pass = 0, n_fail = 0, viol = 0, cyc = 0, t_acc = 0, lat = 0;
    logic [63:0] seq_log;
    logic [63:0] sa_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] ch1;

    function automatic logic [31:0] rf(logic [31:0] h, logic [31:0] iv);
        logic [31:0] r;
        logic [7:0]  x;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            x = h[31-8*i -: 8] ^ iv[31-8*((i+1)%4) -: 8];
            r[31-8*i -: 8] = {x[6:0], x[7]} + 8'h3C + 8'(i);
        end
        return r;
    endfunction

    function automatic logic [31:0] hblk(logic [31:0] blk, logic [31:0] ch, int nr);
        logic [31:0] h;
        h = rf(blk, ch);
        for (int k = 1; k < nr; k++) h = rf(h, ch);
        return h ^ ch;
    endfunction

    function automatic logic [31:0] hmsg(logic [31:0] iv, logic [63:0] data, int n, int nr);
        logic [31:0] ch, blk;
        int idx;
        ch = iv;
        for (int b = 0; b < (n + 3) / 4; b++) begin
            blk = '0;
            for (int j = 0; j < 4; j++) begin
                idx = 4 * b + j;
                if (idx < n) blk[31-8*j -: 8] = data[63-8*idx -: 8];
            end
            ch = hblk(blk, ch, nr);
        end
        return ch;
    endfunction

    hash_ctrl #(.NUM_ROUNDS(4), .CNT_W(4)) u_dut0 (
        .clk(clk), .reset(rst0), .start(start), .iv_in(iv_in), .msg_byte(msg_byte),
        .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(msg_ready0),
        .rnd_state(rnd_state0), .rnd_h_in(rnd_h_in0), .rnd_iv(rnd_iv0), .rnd_h_out(rnd_h_out0),
        .digest(digest0), .digest_valid(digest_valid0), .digest_ready(digest_ready), .busy(busy0)
    );

    hash_ctrl #(.NUM_ROUNDS(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .reset(rst1), .start(start), .iv_in(iv_in), .msg_byte(msg_byte),
        .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(msg_ready1),
        .rnd_state(rnd_state1), .rnd_h_in(rnd_h_in1), .rnd_iv(rnd_iv1), .rnd_h_out(rnd_h_out1),
        .digest(digest1), .digest_valid(digest_valid1), .digest_ready(digest_ready), .busy(busy1)
    );

    // Toy round datapath: register updated in SA/ROUND, cleared at the FINAL edge.
    always @(posedge clk or negedge rst0) begin
        if (!rst0) h_dp0 <= '0;
        else if (rnd_state0 == 3'd1 || rnd_state0 == 3'd2) h_dp0 <= rf(rnd_h_in0, rnd_iv0);
        else if (rnd_state0 == 3'd3) h_dp0 <= '0;
    end
    assign rnd_h_out0 = (rnd_state0 == 3'd3) ? (h_dp0 ^ rnd_iv0) : h_dp0;

    always @(posedge clk or negedge rst1) begin
        if (!rst1) h_dp1 <= '0;
        else if (rnd_state1 == 3'd1 || rnd_state1 == 3'd2) h_dp1 <= rf(rnd_h_in1, rnd_iv1);
        else if (rnd_state1 == 3'd3) h_dp1 <= '0;
    end
    assign rnd_h_out1 = (rnd_state1 == 3'd3) ? (h_dp1 ^ rnd_iv1) : h_dp1;

    assign msg_ready_m    = sel ? msg_ready1    : msg_ready0;
    assign digest_valid_m = sel ? digest_valid1 : digest_valid0;
    assign busy_m         = sel ? busy1         : busy0;
    assign rnd_state_m    = sel ? rnd_state1    : rnd_state0;
    assign rnd_h_in_m     = sel ? rnd_h_in1     : rnd_h_in0;
    assign rnd_iv_m       = sel ? rnd_iv1       : rnd_iv0;
    assign digest_m       = sel ? digest1       : digest0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: log the cycle's outputs at the falling edge, return 1 ns after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (rnd_state_m != 3'd0) seq_log = {seq_log[59:0], 1'b0, rnd_state_m};
        if (rnd_state_m == 3'd1) sa_q.push_back({rnd_h_in_m, rnd_iv_m});
        if ((rnd_state_m inside {3'd1, 3'd2, 3'd3}) && (msg_ready_m || !busy_m)) viol++;
        if ((rnd_state_m == 3'd0 || rnd_state_m == 3'd4) && (rnd_h_in_m != 0 || rnd_iv_m != 0)) viol++;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clear_log();
        seq_log = '0;
        sa_q.delete();
        viol = 0;
    endtask

    task automatic send_msg(input logic [31:0] iv, input logic [63:0] data, input int n, input bit push);
        int t;
        if (push) exp_q.push_back(hmsg(iv, data, n, sel ? 1 : 4));
        start = 1'b1;
        iv_in = iv;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            msg_byte  = data[63-8*i -: 8];
            msg_valid = 1'b1;
            msg_last  = (i == n - 1);
            t = 0;
            while (!msg_ready_m && t < 100) begin
                tick();
                t++;
            end
            chk("ready_wait", 64'(t < 100), 64'd1);
            t_acc = cyc;
            tick();
        end
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    task automatic wait_digest(input int hold, input bit pulse_start, output int latency);
        int          t, bad;
        logic [31:0] e, d0;
        t = 0;
        while (!digest_valid_m && t < 200) begin
            tick();
            t++;
        end
        chk("dvalid_wait", 64'(digest_valid_m), 64'd1);
        latency = cyc - t_acc;
        e = 'x;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("digest", 64'(digest_m), 64'(e));
        bad = 0;
        d0  = e;
        for (int k = 0; k < hold; k++) begin
            if (pulse_start && k == 2) begin
                start = 1'b1;
                iv_in = 32'hFFFF_FFFF;
            end
            tick();
            start = 1'b0;
            if (!digest_valid_m || digest_m !== d0) bad++;
        end
        if (hold > 0) chk("hold_stable", 64'(bad), 64'd0);
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;
        chk("idle_after_ready", {busy_m, rnd_state_m}, 64'd0);
    endtask

    initial begin
        int t;
        rst0 = 1'b0; rst1 = 1'b0; sel = 1'b0;
        start = 1'b0; msg_valid = 1'b0; msg_last = 1'b0; digest_ready = 1'b0;
        iv_in = '0; msg_byte = '0;
        clear_log();
        tick(); tick();
        chk("rst_state", rnd_state_m, 0);
        chk("rst_busy_ready_dv", {busy_m, msg_ready_m, digest_valid_m}, 0);
        chk("rst_digest", digest_m, 0);
        chk("rst_hin_iv", {rnd_h_in_m, rnd_iv_m}, 0);
        rst0 = 1'b1;
        tick();
        msg_valid = 1'b1; msg_byte = 8'h55;
        tick(); tick();
        chk("idle_ignores_valid", {busy_m, msg_ready_m}, 0);
        msg_valid = 1'b0;

        // Single full block
        clear_log();
        send_msg(32'h0102_0304, 64'h1020_3040_0000_0000, 4, 1);
        wait_digest(0, 0, lat);
        chk("t1_seq", seq_log, 64'h12_2234);
        chk("t1_sa_count", sa_q.size(), 1);
        chk("t1_sa_hin", sa_q[0][63:32], 32'h1020_3040);
        chk("t1_sa_iv", sa_q[0][31:0], 32'h0102_0304);
        chk("t1_latency", lat, 6);
        chk("t1_viol", viol, 0);

        // Padding
        clear_log();
        send_msg(32'hDEAD_BEEF, 64'hA1B2_0000_0000_0000, 2, 1);
        wait_digest(0, 0, lat);
        chk("pad_seq", seq_log, 64'h12_2234);
        chk("pad_sa_hin", sa_q[0][63:32], 32'hA1B2_0000);
        chk("pad_latency", lat, 6);

        // Two blocks
        clear_log();
        ch1 = hblk(32'h1122_3344, 32'h0F1E_2D3C, 4);
        send_msg(32'h0F1E_2D3C, 64'h1122_3344_5566_7788, 8, 1);
        wait_digest(0, 0, lat);
        chk("two_seq", seq_log, 64'h1222_3122_234);
        chk("two_sa_count", sa_q.size(), 2);
        chk("two_sa2_hin", sa_q[1][63:32], 32'h5566_7788);
        chk("two_sa2_iv_chain", sa_q[1][31:0], ch1);
        chk("two_viol", viol, 0);
        chk("two_latency", lat, 6);

        // Back-pressure with a start pulse while the digest is held
        clear_log();
        send_msg(32'h1357_2468, 64'hC0FF_EE00_0000_0000, 3, 1);
        wait_digest(5, 1, lat);
        tick();
        chk("bp_start_ignored", busy_m, 0);
        iv_in = '0;

        // Reset in the second ROUND cycle, then a fresh run of the first message
        clear_log();
        send_msg(32'h0102_0304, 64'h1020_3040_0000_0000, 4, 0);
        t = 0;
        while (rnd_state_m != 3'd2 && t < 20) begin
            tick();
            t++;
        end
        tick();
        chk("rr_in_round", rnd_state_m, 2);
        rst0 = 1'b0;
        #1;
        chk("rr_state", rnd_state_m, 0);
        chk("rr_busy_ready", {busy_m, msg_ready_m, digest_valid_m}, 0);
        tick();
        rst0 = 1'b1;
        tick();
        clear_log();
        send_msg(32'h0102_0304, 64'h1020_3040_0000_0000, 4, 1);
        wait_digest(0, 0, lat);
        chk("rr_rerun_seq", seq_log, 64'h12_2234);
        chk("rr_rerun_viol", viol, 0);

        // Single-round build
        rst0 = 1'b0;
        sel  = 1'b1;
        tick();
        chk("r1_rst_state", {busy_m, rnd_state_m}, 0);
        rst1 = 1'b1;
        tick();
        clear_log();
        send_msg(32'h0102_0304, 64'h1020_3040_0000_0000, 4, 1);
        wait_digest(0, 0, lat);
        chk("r1_seq", seq_log, 64'h134);
        chk("r1_latency", lat, 3);
        chk("r1_sa_hin", sa_q[0][63:32], 32'h1020_3040);
        clear_log();
        send_msg(32'h0F1E_2D3C, 64'h1122_3344_5566_7788, 8, 1);
        wait_digest(0, 0, lat);
        chk("r1_two_seq", seq_log, 64'h1_3134);
        chk("r1_two_iv_chain", sa_q[1][31:0], hblk(32'h1122_3344, 32'h0F1E_2D3C, 1));
        chk("r1_two_latency", lat, 3);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
